// File: rtl/b06_responder.sv
// Peer-side responder for the b06 interrupt controller: produces eql/cont_eql from a data
// comparator, a terminal counter and an alarm tally. Optional MATCH watchdog: B06_RESP_WDOG_EN.
module b06_responder #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 4,
  parameter int TERM     = 9,
  parameter int WDOG_LIM = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        cc_mux,
  input  logic [1:0]        uscite,
  input  logic              enable_count,
  input  logic              ackout,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] ref_val,
  output logic              eql,
  output logic              cont_eql,
  output logic [CNT_W-1:0]  cnt,
  output logic [3:0]        alarm_cnt,
  output logic              wdog_to
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    MATCH = 2'b10,
    ACKED = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  // Out-of-range parameters would silently truncate the terminal compare.
  if (TERM >= (1 << CNT_W) || WDOG_LIM < 1) begin : g_param_check
    $error("b06_responder: TERM must fit in CNT_W bits and WDOG_LIM must be >= 1");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_eql;
  logic              r_cont_eql;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_alarm_cnt;
  logic [1:0]        r_usc_q;
  logic [DATA_W-1:0] r_snap;
  logic              w_cmp;
  logic              w_wdog_hit;
  logic              w_alarm_entry;

  always_comb begin
    unique case (cc_mux)
      2'b00:   w_cmp = 1'b0;
      2'b01:   w_cmp = (din == ref_val);
      2'b10:   w_cmp = (din == ~ref_val);
      default: w_cmp = (din == r_snap);
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (cc_mux != 2'b00) w_state_nxt = ARMED;
      ARMED: begin
        if (cc_mux == 2'b00) w_state_nxt = IDLE;
        else if (w_cmp)      w_state_nxt = MATCH;
      end
      MATCH: begin
        if (ackout || w_wdog_hit) w_state_nxt = ACKED;
        else if (!w_cmp)          w_state_nxt = ARMED;
      end
      default: if (!ackout) w_state_nxt = IDLE;
    endcase
  end

  assign w_alarm_entry = (uscite == 2'b11) && (r_usc_q != 2'b11);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: snap is an ordinary register, so it is reset along with the rest of the state.
      r_state     <= IDLE;
      r_eql       <= 1'b0;
      r_cont_eql  <= 1'b0;
      r_cnt       <= '0;
      r_alarm_cnt <= '0;
      r_usc_q     <= 2'b00;
      r_snap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_eql      <= (w_state_nxt == MATCH);
      r_cont_eql <= (r_cnt == TERM_V);
      r_usc_q    <= uscite;
      if (enable_count) r_cnt <= (r_cnt == TERM_V) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && cc_mux != 2'b00) r_snap <= din;
      if (w_alarm_entry && r_alarm_cnt != 4'd15) r_alarm_cnt <= r_alarm_cnt + 4'd1;
    end
  end

`ifdef B06_RESP_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIM + 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_wdog_to;

  // Timer holds the number of completed MATCH cycles; the limit cycle forces ACKED unless acked.
  assign w_wdog_hit = (r_state == MATCH) && (r_wdog == WD_W'(WDOG_LIM - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wdog    <= '0;
      r_wdog_to <= 1'b0;
    end else begin
      r_wdog_to <= w_wdog_hit && !ackout;
      r_wdog    <= (r_state == MATCH && w_state_nxt == MATCH) ? r_wdog + 1'b1 : '0;
    end
  end

  assign wdog_to = r_wdog_to;
`else
  assign w_wdog_hit = 1'b0;
  assign wdog_to    = 1'b0;
`endif

  assign eql       = r_eql;
  assign cont_eql  = r_cont_eql;
  assign cnt       = r_cnt;
  assign alarm_cnt = r_alarm_cnt;

endmodule
